im_loader: RTL and testbench

Hardware program loader for the single-cycle MIPS core. It receives a framed byte stream over a valid/ready interface, assembles big-endian 32-bit words, and writes them into instruction memory starting at word 0. It holds the CPU in reset while loading and releases it once the frame checksum verifies. When the core raises halt, the loader re-arms for the next program.

---
 rtl/im_loader_pkg.sv | 26 ++
 rtl/im_loader_word_assembler.sv | 44 ++++
 rtl/im_loader.sv | 107 ++++++++++
 tb/tb_im_loader.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and frame geometry constants.
package im_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    RUN    = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int LEN_W          = 8 * HDR_BYTES;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  // States in which the loader consumes stream bytes.
  function automatic logic accepts_byte(input state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/im_loader_word_assembler.sv
// Packs a byte stream MSB-first into 32-bit words; word_valid pulses for one
// cycle after the last byte of each word is accepted.
module word_assembler
  import im_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_done,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [BYTE_IDX_W-1:0] IDX_ONE  = BYTE_IDX_W'(1);

  logic [BYTE_IDX_W-1:0] byte_idx;
  logic [WORD_W-9:0]     shift;

  // Combinational strobe so the parent can register the word address on the same edge.
  assign word_done = byte_valid && (byte_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx   <= '0;
      shift      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= word_done;
      if (clear) begin
        byte_idx <= '0;
        shift    <= '0;
      end else if (byte_valid) begin
        byte_idx <= byte_idx + IDX_ONE;
        shift    <= {shift[WORD_W-17:0], byte_data};
        if (word_done) word <= {shift, byte_data};
      end
    end
  end

endmodule

// File: rtl/im_loader.sv
// Framed byte-stream program loader: fills instruction memory from word 0,
// holds the core in reset while loading and releases it on a good checksum.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int IM_DEPTH = 1024,
  parameter int ADDR_W   = $clog2(IM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              halt_sig,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0]    IDX_ONE = (ADDR_W + 1)'(1);
  localparam logic [LEN_W-1:0]   DEPTH_N = LEN_W'(IM_DEPTH);

  state_t            state, state_next;
  logic [7:0]        len_hi;
  logic [7:0]        xor_acc;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W:0]   word_idx;
  logic [LEN_W-1:0]  n_in;
  logic              hs;
  logic              data_hs;
  logic              word_done;
  logic              last_word;

  assign in_ready  = accepts_byte(state);
  assign cpu_reset = (state != RUN);
  assign done      = (state == RUN);
  assign error     = (state == ERR);

  assign hs        = in_valid && in_ready;
  assign data_hs   = hs && (state == DATA);
  assign n_in      = {len_hi, in_data};
  assign last_word = (word_idx + IDX_ONE) == n_words;

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (state == IDLE),
    .byte_valid (data_hs),
    .byte_data  (in_data),
    .word_done  (word_done),
    .word_valid (im_we),
    .word       (im_wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   state_next = LEN_HI;
      LEN_HI: if (hs) state_next = LEN_LO;
      LEN_LO: begin
        if (hs) begin
          if (n_in > DEPTH_N)   state_next = ERR;
          else if (n_in == '0)  state_next = CHK;
          else                  state_next = DATA;
        end
      end
      DATA:   if (word_done && last_word) state_next = CHK;
      CHK:    if (hs) state_next = (in_data == xor_acc) ? RUN : ERR;
      RUN:    if (halt_sig) state_next = IDLE;
      ERR:    state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  // Frame bookkeeping; memory contents themselves are never touched here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_hi   <= '0;
      n_words  <= '0;
      xor_acc  <= '0;
      word_idx <= '0;
      im_addr  <= '0;
    end else begin
      if (state == IDLE) begin
        xor_acc  <= '0;
        word_idx <= '0;
      end else if (hs && (state != CHK)) begin
        xor_acc <= xor_acc ^ in_data;
      end
      if (hs && (state == LEN_HI)) len_hi  <= in_data;
      if (hs && (state == LEN_LO)) n_words <= n_in[ADDR_W:0];
      if (word_done) begin
        im_addr  <= word_idx[ADDR_W-1:0];
        word_idx <= word_idx + IDX_ONE;
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: expected memory writes are queued as frames
// are built and checked against every im_we pulse.
module tb_im_loader;

  localparam int IM_DEPTH = 1024;
  localparam int ADDR_W   = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              halt_sig;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  im_loader #(.IM_DEPTH(IM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .halt_sig  (halt_sig),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int                checks = 0;
  int                errors = 0;
  int                we_cnt = 0;
  int                base;
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] mon_e;
  logic [7:0]        tx[$];
  logic [31:0]       mem [IM_DEPTH];
  logic              hs_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic void push_exp(input int addr, input logic [31:0] d);
    exp_q.push_back({ADDR_W'(addr), d});
  endfunction

  function automatic logic [31:0] pat(input int i, input logic [31:0] seed);
    return seed ^ (32'(i) * 32'h9E3779B1);
  endfunction

  // Memory image as seen by the core, plus handshake history for latency checks.
  always @(posedge clk) begin
    hs_prev <= in_valid && in_ready;
    if (im_we) mem[im_addr] <= im_wdata;
  end

  always @(negedge clk) begin
    if (im_we) begin
      we_cnt++;
      chk_bit("we_latency", hs_prev, 1'b1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL we_unexpected: observed write addr %0h data %0h, required no write", im_addr, im_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("we_addr", 32'(im_addr), 32'(mon_e[ADDR_W+31:32]));
        chk("we_data", im_wdata, mon_e[31:0]);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the handshake plus gap.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed in_ready 0 for %0d cycles, required 1", n);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_tx(input int maxgap);
    int g;
    foreach (tx[i]) begin
      g = (maxgap == 0 || i == tx.size() - 1) ? 0 : int'($urandom_range(maxgap, 1));
      send_byte(tx[i], g);
    end
  endtask

  task automatic build_frame(input int n, input logic [31:0] seed);
    logic [7:0]  x;
    logic [31:0] w;
    tx.delete();
    tx.push_back(8'(n >> 8));
    tx.push_back(8'(n));
    x = 8'(n >> 8) ^ 8'(n);
    for (int i = 0; i < n; i++) begin
      w = pat(i, seed);
      push_exp(i, w);
      for (int k = 3; k >= 0; k--) begin
        tx.push_back(w[8*k +: 8]);
        x = x ^ w[8*k +: 8];
      end
    end
    tx.push_back(x);
  endtask

  task automatic check_reset_vals(input string tag);
    chk_bit({tag, "_in_ready"}, in_ready, 1'b0);
    chk_bit({tag, "_im_we"}, im_we, 1'b0);
    chk({tag, "_im_addr"}, 32'(im_addr), 32'h0);
    chk({tag, "_im_wdata"}, im_wdata, 32'h0);
    chk_bit({tag, "_cpu_reset"}, cpu_reset, 1'b1);
    chk_bit({tag, "_done"}, done, 1'b0);
    chk_bit({tag, "_error"}, error, 1'b0);
  endtask

  task automatic check_run(input string tag);
    chk_bit({tag, "_done"}, done, 1'b1);
    chk_bit({tag, "_cpu_reset"}, cpu_reset, 1'b0);
    chk_bit({tag, "_error"}, error, 1'b0);
    chk_bit({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_halt();
    halt_sig = 1'b1;
    @(negedge clk);
    halt_sig = 1'b0;
    chk_bit("halt_cpu_reset", cpu_reset, 1'b1);
    chk_bit("halt_done", done, 1'b0);
    chk_bit("halt_in_ready", in_ready, 1'b0);
    @(negedge clk);
    chk_bit("reload_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    halt_sig = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;
    #1 chk_bit("idle_in_ready", in_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk_bit("len_hi_in_ready", in_ready, 1'b1);

    // Good frame, back-to-back bytes.
    tx = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h0A, 8'h24, 8'h02, 8'h00, 8'h05, 8'h1E};
    push_exp(0, 32'h3401000A);
    push_exp(1, 32'h24020005);
    base = we_cnt;
    send_tx(0);
    check_run("good");
    chk("good_we_count", 32'(we_cnt - base), 32'd2);
    @(negedge clk);
    chk("good_im0", mem[0], 32'h3401000A);
    chk("good_im1", mem[1], 32'h24020005);
    do_halt();

    // Same frame with stalls between bytes.
    tx = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h0A, 8'h24, 8'h02, 8'h00, 8'h05, 8'h1E};
    push_exp(0, 32'h3401000A);
    push_exp(1, 32'h24020005);
    base = we_cnt;
    send_tx(3);
    check_run("stall");
    chk("stall_we_count", 32'(we_cnt - base), 32'd2);
    do_halt();

    // Reload a one-word program; word 1 must survive.
    tx = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
    push_exp(0, 32'hAABBCCDD);
    base = we_cnt;
    send_tx(2);
    check_run("reload");
    chk("reload_we_count", 32'(we_cnt - base), 32'd1);
    @(negedge clk);
    chk("reload_im0", mem[0], 32'hAABBCCDD);
    chk("reload_im1", mem[1], 32'h24020005);
    do_halt();

    // Halt outside RUN is ignored.
    halt_sig = 1'b1;
    @(negedge clk);
    halt_sig = 1'b0;
    chk_bit("stray_halt_in_ready", in_ready, 1'b1);
    chk_bit("stray_halt_cpu_reset", cpu_reset, 1'b1);

    // Empty frame.
    tx = '{8'h00, 8'h00, 8'h00};
    base = we_cnt;
    send_tx(0);
    check_run("empty");
    chk("empty_we_count", 32'(we_cnt - base), 32'd0);
    do_halt();

    // Full-depth frame: addresses 0 .. IM_DEPTH-1.
    build_frame(IM_DEPTH, 32'h5A5A0F0F);
    base = we_cnt;
    send_tx(0);
    check_run("full");
    chk("full_we_count", 32'(we_cnt - base), 32'(IM_DEPTH));
    @(negedge clk);
    chk("full_im_last", mem[IM_DEPTH-1], pat(IM_DEPTH - 1, 32'h5A5A0F0F));
    chk("full_im_addr", 32'(im_addr), 32'(IM_DEPTH - 1));
    do_halt();

    // Reset mid-frame after a partial word.
    tx = '{8'h00, 8'h01, 8'h34, 8'h01};
    base = we_cnt;
    send_tx(0);
    #2 reset = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_we_count", 32'(we_cnt - base), 32'd0);
    reset = 1'b1;
    tx = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h0A, 8'h24, 8'h02, 8'h00, 8'h05, 8'h1E};
    push_exp(0, 32'h3401000A);
    push_exp(1, 32'h24020005);
    send_tx(1);
    check_run("after_rst");
    @(negedge clk);
    chk("after_rst_im0", mem[0], 32'h3401000A);
    chk("after_rst_im1", mem[1], 32'h24020005);
    do_halt();

    // Bad checksum: both words written, then sticky error.
    tx = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h0A, 8'h24, 8'h02, 8'h00, 8'h05, 8'h1F};
    push_exp(0, 32'h3401000A);
    push_exp(1, 32'h24020005);
    base = we_cnt;
    send_tx(0);
    chk_bit("badchk_error", error, 1'b1);
    chk_bit("badchk_cpu_reset", cpu_reset, 1'b1);
    chk_bit("badchk_done", done, 1'b0);
    chk_bit("badchk_in_ready", in_ready, 1'b0);
    chk("badchk_we_count", 32'(we_cnt - base), 32'd2);
    in_valid = 1'b1;
    in_data  = 8'h00;
    halt_sig = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    halt_sig = 1'b0;
    chk_bit("badchk_sticky_error", error, 1'b1);
    chk_bit("badchk_sticky_in_ready", in_ready, 1'b0);

    // Oversize length (1025 words).
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tx = '{8'h04, 8'h01};
    base = we_cnt;
    send_tx(0);
    chk_bit("oversize_error", error, 1'b1);
    chk_bit("oversize_in_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(negedge clk);
    chk_bit("oversize_hold_in_ready", in_ready, 1'b0);
    chk_bit("oversize_hold_cpu_reset", cpu_reset, 1'b1);
    in_valid = 1'b0;
    chk("oversize_we_count", 32'(we_cnt - base), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
